// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
// Shares the CPU's single AXI3 master port between the instruction-fetch
// requester (read only) and the data requester (read and write).
// One read transaction is outstanding at a time; the two read requesters are
// served round-robin. The data-side write runs in its own FSM, concurrently
// with reads. Data reads are held off while a write is in flight so a read
// can never overtake an earlier write to the same location.
//
// Read FSM
//   state  | meaning
//   R_IDLE | arbitrate between i_arvalid and (unmasked) d_arvalid
//   R_ADDR | drive latched request on AR channel until m_arready
//   R_DATA | accept beats, route matching RID to the owner, end on rlast
//
// Write FSM
//   state    | meaning
//   W_IDLE   | wait for d_awvalid, accept it and latch address/length
//   W_ACTIVE | AW and W channels complete independently, in any order
//   W_RESP   | wait for a B response carrying DATA_ID

module axi_master_arbiter (
   input  logic        clk,
   input  logic        resetn,
   // instruction read requester
   input  logic        i_arvalid,
   input  logic [31:0] i_araddr,
   input  logic [3:0]  i_arlen,
   output logic        i_arready,
   output logic [31:0] i_rdata,
   output logic        i_rvalid,
   output logic        i_rlast,
   // data read requester
   input  logic        d_arvalid,
   input  logic [31:0] d_araddr,
   input  logic [3:0]  d_arlen,
   output logic        d_arready,
   output logic [31:0] d_rdata,
   output logic        d_rvalid,
   output logic        d_rlast,
   // data write requester
   input  logic        d_awvalid,
   input  logic [31:0] d_awaddr,
   input  logic [3:0]  d_awlen,
   output logic        d_awready,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   input  logic        d_wlast,
   input  logic        d_wvalid,
   output logic        d_wready,
   output logic        d_bvalid,
   // AXI read address
   output logic [3:0]  m_arid,
   output logic [31:0] m_araddr,
   output logic [3:0]  m_arlen,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   output logic [1:0]  m_arlock,
   output logic [3:0]  m_arcache,
   output logic [2:0]  m_arprot,
   // AXI read data
   input  logic [3:0]  m_rid,
   input  logic [31:0] m_rdata,
   input  logic        m_rlast,
   input  logic        m_rvalid,
   output logic        m_rready,
   // AXI write address
   output logic [3:0]  m_awid,
   output logic [31:0] m_awaddr,
   output logic [3:0]  m_awlen,
   output logic        m_awvalid,
   input  logic        m_awready,
   output logic [2:0]  m_awsize,
   output logic [1:0]  m_awburst,
   output logic [1:0]  m_awlock,
   output logic [3:0]  m_awcache,
   output logic [2:0]  m_awprot,
   // AXI write data
   output logic [3:0]  m_wid,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   output logic        m_wlast,
   output logic        m_wvalid,
   input  logic        m_wready,
   // AXI write response
   input  logic [3:0]  m_bid,
   input  logic        m_bvalid,
   output logic        m_bready
);

   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_ACTIVE = 2'd1,
      W_RESP   = 2'd2
   } w_state_t;

   r_state_t    r_state_q, r_state_d;
   w_state_t    w_state_q, w_state_d;

   logic [31:0] ar_addr_q;
   logic [3:0]  ar_len_q;
   logic [3:0]  ar_id_q;
   logic        last_grant_data_q;   // 1: data was granted most recently

   logic [31:0] aw_addr_q;
   logic [3:0]  aw_len_q;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        d_cand;
   logic        pick_data;
   logic        pick_inst;
   logic        rid_match;

   // ------------------------------------------------------------------
   // Read side
   // ------------------------------------------------------------------

   // Data reads may not start while any write is outstanding.
   assign d_cand    = d_arvalid & (w_state_q == W_IDLE);
   // On a tie the requester not granted last time wins.
   assign pick_data = d_cand & (~i_arvalid | ~last_grant_data_q);
   assign pick_inst = i_arvalid & ~pick_data;
   assign rid_match = (m_rid == ar_id_q);

   // Read state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state_q <= R_IDLE;
      end else begin
         r_state_q <= r_state_d;
      end
   end

   // Read next-state logic.
   always_comb begin
      r_state_d = r_state_q;
      case (r_state_q)
         R_IDLE: begin
            if (pick_inst || pick_data) begin
               r_state_d = R_ADDR;
            end
         end
         R_ADDR: begin
            if (m_arready) begin
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (m_rvalid && m_rlast && rid_match) begin
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read outputs: grant pulses, AR valid, R acceptance and beat routing.
   always_comb begin
      i_arready = 1'b0;
      d_arready = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      i_rvalid  = 1'b0;
      i_rlast   = 1'b0;
      d_rvalid  = 1'b0;
      d_rlast   = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            i_arready = pick_inst;
            d_arready = pick_data;
         end
         R_ADDR: begin
            m_arvalid = 1'b1;
         end
         R_DATA: begin
            // Beats with a foreign RID are accepted and dropped here.
            m_rready = 1'b1;
            if (m_rvalid && rid_match) begin
               if (ar_id_q == INST_ID) begin
                  i_rvalid = 1'b1;
                  i_rlast  = m_rlast;
               end else begin
                  d_rvalid = 1'b1;
                  d_rlast  = m_rlast;
               end
            end
         end
         default: ;
      endcase
   end

   // Latch the winning request and remember who won.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ar_addr_q         <= 32'd0;
         ar_len_q          <= 4'd0;
         ar_id_q           <= INST_ID;
         last_grant_data_q <= 1'b0;
      end else if (i_arready || d_arready) begin
         ar_addr_q         <= d_arready ? d_araddr : i_araddr;
         ar_len_q          <= d_arready ? d_arlen  : i_arlen;
         ar_id_q           <= d_arready ? DATA_ID  : INST_ID;
         last_grant_data_q <= d_arready;
      end
   end

   assign m_arid    = ar_id_q;
   assign m_araddr  = ar_addr_q;
   assign m_arlen   = ar_len_q;
   assign m_arsize  = 3'b010;
   assign m_arburst = 2'b01;
   assign m_arlock  = 2'b00;
   assign m_arcache = 4'b0000;
   assign m_arprot  = 3'b000;

   assign i_rdata   = m_rdata;
   assign d_rdata   = m_rdata;

   // ------------------------------------------------------------------
   // Write side
   // ------------------------------------------------------------------

   // Write state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         w_state_q <= W_IDLE;
      end else begin
         w_state_q <= w_state_d;
      end
   end

   // Write outputs: AW accept pulse, channel valids/readies, B completion.
   always_comb begin
      d_awready = 1'b0;
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      d_wready  = 1'b0;
      m_bready  = 1'b0;
      d_bvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            d_awready = d_awvalid;
         end
         W_ACTIVE: begin
            m_awvalid = ~aw_done_q;
            m_wvalid  = d_wvalid & ~w_done_q;
            d_wready  = m_wready & ~w_done_q;
         end
         W_RESP: begin
            // A response with a foreign BID is consumed without effect.
            m_bready = 1'b1;
            d_bvalid = m_bvalid & (m_bid == DATA_ID);
         end
         default: ;
      endcase
   end

   // AW/W completion flags; this cycle's handshakes count toward the exit.
   always_comb begin
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      if (w_state_q == W_IDLE) begin
         if (d_awvalid) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
         end
      end else if (w_state_q == W_ACTIVE) begin
         if (m_awvalid && m_awready) begin
            aw_done_d = 1'b1;
         end
         if (m_wvalid && m_wready && d_wlast) begin
            w_done_d = 1'b1;
         end
      end
   end

   // Write next-state logic.
   always_comb begin
      w_state_d = w_state_q;
      case (w_state_q)
         W_IDLE: begin
            if (d_awvalid) begin
               w_state_d = W_ACTIVE;
            end
         end
         W_ACTIVE: begin
            if (aw_done_d && w_done_d) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (d_bvalid) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Completion flags and latched write request.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         aw_addr_q <= 32'd0;
         aw_len_q  <= 4'd0;
      end else begin
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         if (d_awready) begin
            aw_addr_q <= d_awaddr;
            aw_len_q  <= d_awlen;
         end
      end
   end

   assign m_awid    = DATA_ID;
   assign m_awaddr  = aw_addr_q;
   assign m_awlen   = aw_len_q;
   assign m_awsize  = 3'b010;
   assign m_awburst = 2'b01;
   assign m_awlock  = 2'b00;
   assign m_awcache = 4'b0000;
   assign m_awprot  = 3'b000;

   assign m_wid     = DATA_ID;
   assign m_wdata   = d_wdata;
   assign m_wstrb   = d_wstrb;
   assign m_wlast   = d_wlast;

endmodule

// File: doc/axi_master_arbiter.md
# axi_master_arbiter

Shares the single AXI3 master port of the CPU between the instruction-fetch requester (read-only) and the data requester (read and write). It issues one read transaction at a time and arbitrates round-robin between the two read requesters. It sequences the data-side write address, data and response channels, and drives the ready signals the requester-side wrappers do not generate. It sits between the instruction/data AXI wrappers and the SoC AXI crossbar.

## Interface
- INST_ID, 4'd0, ARID used for instruction reads; return beats with this RID go to the instruction side
- DATA_ID, 4'd1, AR/AW/W ID used for data transactions; RID/BID matched against it
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- i_arvalid, i_araddr, i_arlen  in  1/32/4  instruction read request
- i_arready  out  1  one-cycle grant pulse; request accepted
- i_rdata, i_rvalid, i_rlast  out  32/1/1  instruction read beats
- d_arvalid, d_araddr, d_arlen  in  1/32/4  data read request
- d_arready  out  1  one-cycle grant pulse
- d_rdata, d_rvalid, d_rlast  out  32/1/1  data read beats
- d_awvalid, d_awaddr, d_awlen  in  1/32/4  data write request
- d_awready  out  1  one-cycle accept pulse
- d_wdata, d_wstrb, d_wlast, d_wvalid  in  32/4/1/1  data write beats
- d_wready  out  1  write beat accepted this cycle
- d_bvalid  out  1  one-cycle write-complete pulse
- m_arid, m_araddr, m_arlen, m_arvalid  out  4/32/4/1  AXI read address; m_arready in 1
- m_rid, m_rdata, m_rlast, m_rvalid  in  4/32/1/1  AXI read data; m_rready out 1
- m_awid, m_awaddr, m_awlen, m_awvalid  out  4/32/4/1  AXI write address; m_awready in 1
- m_wid, m_wdata, m_wstrb, m_wlast, m_wvalid  out  4/32/4/1/1  AXI write data; m_wready in 1
- m_bid, m_bvalid  in  4/1  AXI write response; m_bready out 1
- m_ar/aw size, burst, lock, cache, prot  out  3/2/2/4/3  constants: 3'b010, 2'b01, 0, 0, 0

## Operation
- Read FSM has three states: R_IDLE, R_ADDR and R_DATA.
- **R_IDLE:** candidates are i_arvalid and d_arvalid. d_arvalid is masked while the write FSM is not W_IDLE; this is the read-after-write ordering rule.
- **Arbitration:** a single candidate wins. With two candidates, the requester not granted last wins. last_grant resets to inst, so the first tie goes to data.
- **Grant:** in the grant cycle, pulse the winner's *_arready, latch addr/len/ID into registers, update last_grant, and move to R_ADDR.
- **R_ADDR:** m_arvalid=1 from the registers, held stable until m_arready; then move to R_DATA.
- **R_DATA:** m_rready=1. A beat with m_rid==latched ID routes combinationally to the owner: *_rvalid=m_rvalid, *_rdata=m_rdata, *_rlast=m_rlast.
- **Read completion:** m_rvalid & m_rlast & ID match moves to R_IDLE.
- **Stray read beats:** beats with a non-matching RID are consumed (rready=1) and dropped.
- Write FSM has three states: W_IDLE, W_ACTIVE and W_RESP.
- **W_IDLE:** on d_awvalid, pulse d_awready, latch awaddr/awlen, clear aw_done/w_done, and move to W_ACTIVE.
- **W_ACTIVE, address:** m_awvalid = !aw_done. An m_awready handshake sets aw_done.
- **W_ACTIVE, data beats:** m_wvalid = d_wvalid & !w_done, d_wready = m_wready & !w_done, and wdata/wstrb/wlast pass through. A handshake with d_wlast sets w_done.
- **AW/W independence:** the AW and W handshakes may complete in either order or in the same cycle.
- **W_ACTIVE exit:** move to W_RESP when aw_done & w_done, including flags set this cycle.
- **W_RESP:** m_bready=1. m_bvalid & m_bid==DATA_ID pulses d_bvalid and moves to W_IDLE. A mismatching BID is consumed and ignored.
- **Concurrency:** the read and write FSMs run concurrently. Instruction reads may overlap an active write; data reads may not.
- **No back-pressure to requesters:** requesters are never stalled mid-burst; the slave paces via ready.

## Timing
- **Reset:** resetn=0 at an edge forces R_IDLE, W_IDLE and last_grant=inst. On the next cycle every handshake output is 0: m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, *_arready, d_awready, d_wready, *_rvalid, d_bvalid.
- **Reset mid-operation:** reset during a transaction abandons it; no completion pulse is produced.
- **Read latency:** grant in cycle N; m_arvalid from N+1. Minimum AR-to-first-beat is set by the slave; R data has zero added latency.
- **Write latency:** d_awready in cycle N; m_awvalid and W passthrough enabled from N+1. d_bvalid is asserted in the same cycle as the accepted m_bvalid.
- **Request holding:** a requester must hold its *valid and address until its *ready pulse.
- **Registered outputs:** all m_* address outputs are registered and stable while valid is high and ready is low.

## Test plan
- **Instruction single read:** i_arvalid, addr 0x1FC00000, len 0; slave arready after 2 cycles, one beat rid=0 data 0x3C1DBFC0 -> i_arready pulses once; m_arid=0; i_rvalid/i_rlast high one cycle with that data; FSM returns to R_IDLE.
- **Simultaneous read requests:** i_arvalid and d_arvalid both raised after reset -> data granted first (m_arid=1, len 7, 8 beats to d_*), then inst granted; a repeated tie then alternates.
- **Write with W before AW:** d_aw addr 0x00001000, len 0; slave wready=1 immediately, awready after 3 cycles, bvalid bid=1 two cycles later -> d_wready in cycle 1, m_awvalid held 3 cycles, d_bvalid single pulse.
- **Read-after-write ordering:** d_arvalid raised while a write is in W_RESP -> d_arready stays 0 until the cycle after d_bvalid; a concurrent i_arvalid is granted meanwhile.
- **Stray RID:** beat with rid=5 during a data burst -> dropped, not seen on d_rvalid or i_rvalid; burst completes normally.
- **Reset mid-burst:** resetn low during beat 3 of 8 -> next cycle all valid/ready outputs 0; the next request is granted normally.
